q_action_selector: RTL and testbench
====================================

// Module: q_action_selector
// PURPOSE
//  Epsilon-greedy action source for the Q-learning update pipeline; the hardware replacement for random bench actions.
//  Per accepted state: reads that state's 4 Q-values from the Q-table read port, takes the signed argmax,
//  substitutes a pseudo-random action with probability eps/256, and emits the 2-bit action on a valid/ready output.
// PARAMETERS
//  STATE_W    6        state index width (64 states)
//  ACT_W      2        action width (NUM_ACT = 4 actions)
//  Q_W        32       Q-value width, signed two's-complement fixed point
//  EPS_W      8        exploration threshold width
//  LFSR_SEED  16'hACE1 LFSR value after reset; must be non-zero
// PORTS
//  clk            in   1               clock, rising edge
//  rst            in   1               synchronous reset, active-low
//  state_in       in   STATE_W         current environment state
//  state_valid    in   1               state_in valid
//  state_ready    out  1               selector can accept a state
//  eps            in   EPS_W           exploration threshold; explore when lfsr[7:0] < eps
//  q_rd_en        out  1               Q-table read strobe
//  q_rd_addr      out  STATE_W+ACT_W   read address = {state, action}
//  q_rd_data      in   Q_W             read data; valid exactly 1 cycle after q_rd_en
//  action_out     out  ACT_W           selected action
//  action_explore out  1               1 = action came from exploration
//  action_valid   out  1               action_out/action_explore valid
//  action_ready   in   1               consumer (update pipeline) accepts action
// BEHAVIOUR
//  Reset (rst==0 at an edge): FSM=IDLE; state_ready=1; action_valid=0, action_out=0, action_explore=0, q_rd_en=0, q_rd_addr=0; LFSR=LFSR_SEED.
//  FSM: IDLE -> READ -> DRAIN -> OUT -> IDLE.
//   IDLE: state_ready=1. On state_valid&&state_ready: latch state_in; sample eps; explore_r = (lfsr[7:0] < eps),
//         rand_act = lfsr[9:8]; LFSR advances exactly once (only here). Go to READ.
//   READ: 4 cycles, q_rd_en=1, q_rd_addr = {state, k}, k = 0,1,2,3 in order.
//   DRAIN: 1 cycle; the last read's data returns.
//   Compare: each returned datum is compared signed against the running max; the first (k=0) initialises it.
//            Replace only on strictly greater, so ties keep the lowest index.
//   OUT: action_valid=1; action_out = explore_r ? rand_act : argmax; action_explore = explore_r.
//        Outputs are held stable until action_ready. On action_valid&&action_ready go to IDLE (action_valid=0 next cycle).
//  Fixed latency: action_valid is first high in the 6th cycle after the accepting edge, independent of explore.
//  state_ready=0 in READ/DRAIN/OUT. No new state is accepted in the same cycle an action is handed off.
//  eps=0: pure greedy. eps=255: explore with probability 255/256.
//  LFSR: 16-bit Galois, x^16+x^14+x^13+x^11+1 (mask 16'hB400), shift right.
//  q_rd_data is ignored outside the cycle after a read.
//  rst low mid-operation aborts the decision; no partial action is emitted.
// CONFIGURATION
//  QSEL_MAXQ_OUT_EN defined: adds output max_q [Q_W-1:0], the greedy max Q of the last decision,
//   valid with action_valid (even when exploring). Used for the gamma*maxQ target term; reset value 0.
//  Undefined: port and register absent; behaviour otherwise identical.
// STRUCTURE
//  Package q_accel_pkg: NUM_STATES, NUM_ACT, Q_W, Q-value typedef, FSM state enum, LFSR_MASK constant.
//  Sub-module qsel_lfsr16 (clk, rst, adv, seed -> value). The FSM, address counter and compare stay in this module.
// TESTING (bench models a 1-cycle-latency Q-table RAM)
//  1 eps=0, state=5, Q[5]={10,-3,40,7} -> q_rd_addr 20,21,22,23; action_out=2, explore=0; valid in 6th cycle after accept.
//  2 eps=0, Q={7,7,1,7} -> action 0 (tie keeps lowest index); Q={-5,-2,-9,-100} -> action 1 (signed compare).
//  3 eps=128, 1000 decisions, arbitrary Q -> explore count 450..550; explored actions each 200..300 of explored;
//    sequence matches the bench LFSR model from seed 16'hACE1.
//  4 action_ready=0 for 10 cycles in OUT -> action_out/valid stable, state_ready=0, q_rd_en=0; handoff on ready=1.
//  5 rst=0 during READ (k=2) -> next cycle all outputs at reset values; next decision uses LFSR_SEED draw again.
//  6 QSEL_MAXQ_OUT_EN, case 1 data with eps=255 -> max_q=40 while action_explore=1.

Source files
------------

// File: rtl/q_accel_pkg.sv
// Shared definitions for the Q-learning accelerator action selector:
// table geometry, Q-value type, selector FSM encoding and the LFSR step.
package q_accel_pkg;

  localparam int STATE_W    = 6;
  localparam int ACT_W      = 2;
  localparam int NUM_STATES = 64;
  localparam int NUM_ACT    = 4;
  localparam int Q_W        = 32;
  localparam int EPS_W      = 8;

  // Galois feedback taps for x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef logic signed [Q_W-1:0] q_val_t;

  typedef enum logic [1:0] {
    SEL_IDLE  = 2'd0,
    SEL_READ  = 2'd1,
    SEL_DRAIN = 2'd2,
    SEL_OUT   = 2'd3
  } sel_state_e;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
    lfsr16_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/qsel_lfsr16.sv
// 16-bit Galois LFSR used as the exploration random source.
// Loads the seed in reset and advances one step per adv pulse.
module qsel_lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic [15:0] seed,
  output logic [15:0] value
);
  import q_accel_pkg::*;

  // LFSR register: seed on reset, single step when advanced.
  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= seed;
    end else if (adv) begin
      value <= lfsr16_next(value);
    end
  end

endmodule

// File: rtl/q_action_selector.sv
// Epsilon-greedy action selector. For each accepted state it reads the four
// Q-values of that state, keeps the signed argmax (ties keep the lowest
// index), optionally substitutes a pseudo-random action and presents the
// result on a valid/ready output. Latency from accept to action_valid is
// fixed at 6 cycles.
// Optional build macro: QSEL_MAXQ_OUT_EN adds the max_q output (greedy max of
// the last decision, valid with action_valid).
module q_action_selector #(
  parameter int          STATE_W   = q_accel_pkg::STATE_W,
  parameter int          ACT_W     = q_accel_pkg::ACT_W,
  parameter int          Q_W       = q_accel_pkg::Q_W,
  parameter int          EPS_W     = q_accel_pkg::EPS_W,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STATE_W-1:0]       state_in,
  input  logic                     state_valid,
  output logic                     state_ready,
  input  logic [EPS_W-1:0]         eps,
  output logic                     q_rd_en,
  output logic [STATE_W+ACT_W-1:0] q_rd_addr,
  input  logic [Q_W-1:0]           q_rd_data,
  output logic [ACT_W-1:0]         action_out,
  output logic                     action_explore,
`ifdef QSEL_MAXQ_OUT_EN
  output logic [Q_W-1:0]           max_q,
`endif
  output logic                     action_valid,
  input  logic                     action_ready
);
  import q_accel_pkg::*;

  localparam logic [ACT_W-1:0] ZERO_K = {ACT_W{1'b0}};
  localparam logic [ACT_W-1:0] ONE_K  = {{(ACT_W-1){1'b0}}, 1'b1};
  localparam logic [ACT_W-1:0] LAST_K = {ACT_W{1'b1}};

  sel_state_e                 state_r;
  sel_state_e                 state_nxt_s;
  logic                       accept_s;
  logic [STATE_W-1:0]         state_lat_r;
  logic                       explore_r;
  logic [ACT_W-1:0]           rand_act_r;
  logic [15:0]                lfsr_s;
  logic                       lfsr_unused_s;
  logic                       rd_pend_r;
  logic [ACT_W-1:0]           rd_idx_r;
  logic signed [Q_W-1:0]      max_r;
  logic signed [Q_W-1:0]      max_nxt_s;
  logic [ACT_W-1:0]           arg_r;
  logic [ACT_W-1:0]           arg_nxt_s;

  // The random source advances exactly once per accepted state.
  qsel_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (accept_s),
    .seed  (LFSR_SEED),
    .value (lfsr_s)
  );

  // Upper LFSR bits do not feed the decision.
  assign lfsr_unused_s = ^lfsr_s[15:EPS_W+ACT_W];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= SEL_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and the accept strobe.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      SEL_IDLE: begin
        if (state_valid && state_ready) begin
          accept_s    = 1'b1;
          state_nxt_s = SEL_READ;
        end else begin
          state_nxt_s = SEL_IDLE;
        end
      end
      SEL_READ: begin
        if (q_rd_addr[ACT_W-1:0] == LAST_K) begin
          state_nxt_s = SEL_DRAIN;
        end else begin
          state_nxt_s = SEL_READ;
        end
      end
      SEL_DRAIN: begin
        state_nxt_s = SEL_OUT;
      end
      SEL_OUT: begin
        if (action_valid && action_ready) begin
          state_nxt_s = SEL_IDLE;
        end else begin
          state_nxt_s = SEL_OUT;
        end
      end
      default: begin
        state_nxt_s = SEL_IDLE;
      end
    endcase
  end

  // Running signed argmax over returning read data; index 0 seeds it and
  // only a strictly greater value replaces it.
  always_comb begin
    max_nxt_s = max_r;
    arg_nxt_s = arg_r;
    if (rd_pend_r) begin
      if ((rd_idx_r == ZERO_K) || ($signed(q_rd_data) > max_r)) begin
        max_nxt_s = $signed(q_rd_data);
        arg_nxt_s = rd_idx_r;
      end else begin
        max_nxt_s = max_r;
        arg_nxt_s = arg_r;
      end
    end else begin
      max_nxt_s = max_r;
      arg_nxt_s = arg_r;
    end
  end

  // Read-return tracking and compare state; data is qualified by the
  // delayed read strobe so stray data outside a read slot is ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_pend_r <= 1'b0;
      rd_idx_r  <= ZERO_K;
      max_r     <= '0;
      arg_r     <= ZERO_K;
    end else begin
      rd_pend_r <= q_rd_en;
      rd_idx_r  <= q_rd_addr[ACT_W-1:0];
      max_r     <= max_nxt_s;
      arg_r     <= arg_nxt_s;
    end
  end

  // Accept-time capture: state, exploration decision and random action.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_lat_r <= {STATE_W{1'b0}};
      explore_r   <= 1'b0;
      rand_act_r  <= ZERO_K;
    end else if (accept_s) begin
      state_lat_r <= state_in;
      explore_r   <= (lfsr_s[EPS_W-1:0] < eps);
      rand_act_r  <= lfsr_s[EPS_W +: ACT_W];
    end
  end

  // Registered handshake and read-port outputs, derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_ready  <= 1'b1;
      q_rd_en      <= 1'b0;
      q_rd_addr    <= {(STATE_W+ACT_W){1'b0}};
      action_valid <= 1'b0;
    end else begin
      state_ready  <= (state_nxt_s == SEL_IDLE);
      q_rd_en      <= (state_nxt_s == SEL_READ);
      action_valid <= (state_nxt_s == SEL_OUT);
      if (accept_s) begin
        q_rd_addr <= {state_in, ZERO_K};
      end else if ((state_r == SEL_READ) && (state_nxt_s == SEL_READ)) begin
        q_rd_addr <= {state_lat_r, q_rd_addr[ACT_W-1:0] + ONE_K};
      end
    end
  end

  // Action result registers, loaded once as the last compare completes and
  // held through the whole OUT phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      action_out     <= ZERO_K;
      action_explore <= 1'b0;
`ifdef QSEL_MAXQ_OUT_EN
      max_q          <= {Q_W{1'b0}};
`endif
    end else if (state_r == SEL_DRAIN) begin
      action_out     <= explore_r ? rand_act_r : arg_nxt_s;
      action_explore <= explore_r;
`ifdef QSEL_MAXQ_OUT_EN
      max_q          <= max_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_q_action_selector.sv
// Self-checking bench for q_action_selector with a 1-cycle-latency Q-table
// RAM model and an independent LFSR reference model.
module tb_q_action_selector;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  state_in;
  logic        state_valid;
  logic        state_ready;
  logic [7:0]  eps;
  logic        q_rd_en;
  logic [7:0]  q_rd_addr;
  logic [31:0] q_rd_data;
  logic [1:0]  action_out;
  logic        action_explore;
  logic        action_valid;
  logic        action_ready;
`ifdef QSEL_MAXQ_OUT_EN
  logic [31:0] max_q;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] model_lfsr;
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  q_action_selector dut (
    .clk            (clk),
    .rst            (rst),
    .state_in       (state_in),
    .state_valid    (state_valid),
    .state_ready    (state_ready),
    .eps            (eps),
    .q_rd_en        (q_rd_en),
    .q_rd_addr      (q_rd_addr),
    .q_rd_data      (q_rd_data),
    .action_out     (action_out),
    .action_explore (action_explore),
`ifdef QSEL_MAXQ_OUT_EN
    .max_q          (max_q),
`endif
    .action_valid   (action_valid),
    .action_ready   (action_ready)
  );

  // Q-table RAM: data one cycle after the strobe, a large decoy otherwise.
  always @(posedge clk) begin
    q_rd_data <= q_rd_en ? mem[q_rd_addr] : 32'h7FFF_FFFF;
  end

  typedef struct {
    logic [5:0]  st;
    logic [7:0]  e;
    logic [31:0] q0, q1, q2, q3;
    logic [1:0]  greedy;
    logic [31:0] qmax;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic ref_greedy(input logic [5:0] s, output logic [1:0] a, output logic [31:0] m);
    logic [31:0] v;
    m = mem[{s, 2'd0}];
    a = 2'd0;
    for (int k = 1; k < 4; k++) begin
      v = mem[{s, 2'(k)}];
      if ($signed(v) > $signed(m)) begin
        m = v;
        a = 2'(k);
      end
    end
  endtask

  task automatic load_vec(input vec_t v);
    mem[{v.st, 2'd0}] = v.q0;
    mem[{v.st, 2'd1}] = v.q1;
    mem[{v.st, 2'd2}] = v.q2;
    mem[{v.st, 2'd3}] = v.q3;
  endtask

  // One complete decision; called at a falling edge.
  task automatic decide(input logic [5:0] s, input logic [7:0] e, input int hold,
                        input logic [1:0] greedy, input logic [31:0] qmax, input bit detail,
                        output logic o_exp, output logic [1:0] o_act);
    logic [15:0] draw;
    logic        exp_x;
    logic [1:0]  exp_a;
    int          c;
    bit          seen;
    draw       = model_lfsr;
    exp_x      = (draw[7:0] < e);
    exp_a      = exp_x ? draw[9:8] : greedy;
    model_lfsr = lfsr_step(model_lfsr);
    if (detail) chk("idle_ready", {31'd0, state_ready}, 32'd1);
    state_in = s; eps = e; state_valid = 1'b1;
    @(posedge clk);
    #1 state_valid = 1'b0;
    c = 0; seen = 1'b0;
    while (!seen && c < 20) begin
      @(negedge clk);
      c++;
      if (detail && c <= 4) begin
        chk("rd_en", {31'd0, q_rd_en}, 32'd1);
        chk("rd_addr", {24'd0, q_rd_addr}, {24'd0, s, 2'(c - 1)});
      end
      if (detail && c == 5) chk("rd_en_drain", {31'd0, q_rd_en}, 32'd0);
      if (action_valid) seen = 1'b1;
    end
    chk("latency", c, 32'd6);
    o_exp = action_explore;
    o_act = action_out;
    chk("action", {30'd0, action_out}, {30'd0, exp_a});
    chk("explore", {31'd0, action_explore}, {31'd0, exp_x});
`ifdef QSEL_MAXQ_OUT_EN
    chk("max_q", max_q, qmax);
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, action_valid}, 32'd1);
      chk("hold_action", {30'd0, action_out}, {30'd0, exp_a});
      chk("hold_state_ready", {31'd0, state_ready}, 32'd0);
      chk("hold_rd_en", {31'd0, q_rd_en}, 32'd0);
    end
    action_ready = 1'b1;
    @(posedge clk);
    #1 action_ready = 1'b0;
    @(negedge clk);
    if (detail) begin
      chk("valid_drop", {31'd0, action_valid}, 32'd0);
      chk("ready_back", {31'd0, state_ready}, 32'd1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state_ready"}, {31'd0, state_ready}, 32'd1);
    chk({tag, "_action_valid"}, {31'd0, action_valid}, 32'd0);
    chk({tag, "_action_out"}, {30'd0, action_out}, 32'd0);
    chk({tag, "_explore"}, {31'd0, action_explore}, 32'd0);
    chk({tag, "_rd_en"}, {31'd0, q_rd_en}, 32'd0);
    chk({tag, "_rd_addr"}, {24'd0, q_rd_addr}, 32'd0);
`ifdef QSEL_MAXQ_OUT_EN
    chk({tag, "_max_q"}, max_q, 32'd0);
`endif
  endtask

  initial begin
    logic        ox;
    logic [1:0]  oa;
    logic [1:0]  ga;
    logic [31:0] gm;
    logic [5:0]  rs;
    int          n_exp;
    int          act_cnt [4];
    int          pm;
    int          c;

    vecs[0] = '{6'd5,  8'd0,   32'd10,         32'hFFFF_FFFD, 32'd40,        32'd7,         2'd2, 32'd40};
    vecs[1] = '{6'd9,  8'd0,   32'd7,          32'd7,         32'd1,         32'd7,         2'd0, 32'd7};
    vecs[2] = '{6'd12, 8'd0,   32'hFFFF_FFFB,  32'hFFFF_FFFE, 32'hFFFF_FFF7, 32'hFFFF_FF9C, 2'd1, 32'hFFFF_FFFE};
    vecs[3] = '{6'd63, 8'd0,   32'd0,          32'd0,         32'd0,         32'd1,         2'd3, 32'd1};
    vecs[4] = '{6'd0,  8'd0,   32'hFFFF_FFFF,  32'h7FFF_FFFF, 32'h8000_0000, 32'd5,         2'd1, 32'h7FFF_FFFF};
    vecs[5] = '{6'd33, 8'd0,   32'd100,        32'd200,       32'd300,       32'd300,       2'd2, 32'd300};
    vecs[6] = '{6'd40, 8'd255, 32'd1,          32'd2,         32'd3,         32'd4,         2'd3, 32'd4};
    vecs[7] = '{6'd41, 8'd1,   32'hFFFF_FFF8,  32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 2'd0, 32'hFFFF_FFF8};

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 8; i++) load_vec(vecs[i]);

    rst = 1'b0; state_in = 6'd0; state_valid = 1'b0; eps = 8'd0; action_ready = 1'b0;
    model_lfsr = 16'hACE1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Directed table: greedy, ties, signed compare, explore extremes.
    for (int i = 0; i < 8; i++) begin
      decide(vecs[i].st, vecs[i].e, 0, vecs[i].greedy, vecs[i].qmax, 1'b1, ox, oa);
    end

    // Back-pressure: 10 cycles of action_ready low in OUT.
    decide(vecs[0].st, 8'd0, 10, vecs[0].greedy, vecs[0].qmax, 1'b1, ox, oa);

    // Statistics: eps=128 over 1000 decisions with arbitrary Q-values.
    n_exp = 0;
    for (int a = 0; a < 4; a++) act_cnt[a] = 0;
    for (int i = 0; i < 1000; i++) begin
      rs = 6'($urandom_range(0, 63));
      ref_greedy(rs, ga, gm);
      decide(rs, 8'd128, 0, ga, gm, 1'b0, ox, oa);
      if (ox === 1'b1) begin
        n_exp++;
        act_cnt[oa]++;
      end
    end
    chk("explore_count_450_550", {31'd0, (n_exp >= 450 && n_exp <= 550)}, 32'd1);
    for (int a = 0; a < 4; a++) begin
      pm = (n_exp > 0) ? (act_cnt[a] * 1000) / n_exp : 0;
      chk($sformatf("explore_act%0d_permille_200_300", a), {31'd0, (pm >= 200 && pm <= 300)}, 32'd1);
    end

    // Ensure a non-zero action is on the outputs before the abort.
    for (int i = 0; i < 4; i++) begin
      mem[{vecs[0].st, 2'(i)}] = (i == 0) ? vecs[0].q0 : (i == 1) ? vecs[0].q1 : (i == 2) ? vecs[0].q2 : vecs[0].q3;
    end
    decide(vecs[0].st, 8'd0, 0, 2'd2, 32'd40, 1'b1, ox, oa);

    // Reset during READ with k=2 aborts the decision and reseeds the LFSR.
    state_in = 6'd20; eps = 8'd0; state_valid = 1'b1;
    @(posedge clk);
    #1 state_valid = 1'b0;
    c = 0;
    repeat (3) begin
      @(negedge clk);
      c++;
    end
    chk("abort_at_k2", {30'd0, q_rd_addr[1:0]}, 32'd2);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("abort");
    rst = 1'b1;
    model_lfsr = 16'hACE1;
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_valid", {31'd0, action_valid}, 32'd0);
    end

    // Seed draw again: explore with eps=255, greedy max still 40.
    decide(vecs[0].st, 8'd255, 0, 2'd2, 32'd40, 1'b1, ox, oa);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
